ftdi_tx: RTL

FTDI_TX -- requirements
Module: ftdi_tx

---
 rtl/ftdi_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ftdi_tx.sv
// FT245 synchronous-FIFO transmitter: FWFT byte FIFO feeding the FTDI write port with bus turnaround.
// Optional macro FTDI_TX_CSUM_EN appends an XOR checksum beat after every byte tagged with s_last.

module ftdi_tx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_60,
  input  logic                        rst_n,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  input  logic                        txe_n,
  input  logic                        rx_active,
  output logic [7:0]                  ftdi_wdata,
  output logic                        ftdi_drive,
  output logic                        wr_n,
  output logic                        tx_active,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef FTDI_TX_CSUM_EN
  localparam int DW = 9;
`else
  localparam int DW = 8;
`endif
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_SEND = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic [DW-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic          wr_n_r;
  logic          drive_r;
  logic          tx_active_r;
  logic [DW-1:0] head_s;
  logic [DW-1:0] wr_entry_s;
  logic          head_last_s;
  logic [7:0]    csum_s;
  logic          push_s;
  logic          xfer_s;
  logic          pop_s;

  assign head_s     = mem_r[rd_ptr_r];
  assign s_ready    = (level_r != LVL_FULL);
  assign push_s     = s_valid && s_ready;
  assign xfer_s     = !wr_n_r && !txe_n;
  assign pop_s      = xfer_s && (state_r == ST_SEND);
  assign level      = level_r;
  assign wr_n       = wr_n_r;
  assign ftdi_drive = drive_r;
  assign tx_active  = tx_active_r;

`ifdef FTDI_TX_CSUM_EN
  logic [7:0] csum_r;
  assign wr_entry_s  = {s_last, s_data};
  assign head_last_s = head_s[8];
  assign csum_s      = csum_r;

  // Running XOR of data beats on the wire; the checksum beat itself restarts it.
  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= 8'h00;
    end else if (pop_s) begin
      csum_r <= csum_fold(csum_r, head_s[7:0]);
    end else if (xfer_s && (state_r == ST_CSUM)) begin
      csum_r <= 8'h00;
    end else begin
      csum_r <= csum_r;
    end
  end
`else
  logic unused_last_s;
  assign unused_last_s = s_last;
  assign wr_entry_s    = s_data;
  assign head_last_s   = 1'b0;
  assign csum_s        = 8'h00;
`endif

  // FIFO storage; validity is defined by the pointers, so the array needs no reset.
  always_ff @(posedge clk_60) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Next-state logic for the bus-ownership FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((level_r != LVL_ZERO) && !rx_active && !txe_n) state_nxt_s = ST_TURN;
        else                                                state_nxt_s = ST_IDLE;
      end
      ST_TURN: state_nxt_s = ST_SEND;
      ST_SEND: begin
        if (!xfer_s)                                  state_nxt_s = ST_IDLE;
        else if (head_last_s)                         state_nxt_s = ST_CSUM;
        else if ((level_r == LVL_ONE) && !push_s)     state_nxt_s = ST_IDLE;
        else if (rx_active)                           state_nxt_s = ST_IDLE;
        else                                          state_nxt_s = ST_SEND;
      end
      ST_CSUM: begin
        if (!xfer_s)                   state_nxt_s = ST_CSUM;
        else if (level_r != LVL_ZERO)  state_nxt_s = ST_SEND;
        else                           state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and registered bus controls; drive is held one cycle past the last strobe.
  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      wr_n_r      <= 1'b1;
      drive_r     <= 1'b0;
      tx_active_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wr_n_r      <= !((state_nxt_s == ST_SEND) || (state_nxt_s == ST_CSUM));
      tx_active_r <= (state_nxt_s != ST_IDLE);
      drive_r     <= (state_nxt_s != ST_IDLE) || (state_r != ST_IDLE);
    end
  end

  // Wire data: checksum during CSUM, otherwise the FIFO head (zero when empty).
  always_comb begin
    if (state_r == ST_CSUM) begin
      ftdi_wdata = csum_s;
    end else if (level_r == LVL_ZERO) begin
      ftdi_wdata = 8'h00;
    end else begin
      ftdi_wdata = head_s[7:0];
    end
  end

endmodule
